// File: rtl/mdu_iterative.sv
// Iterative multiply/divide unit beside the execute-stage ALU.
// Radix-2 shift-add multiply and restoring divide feeding HI/LO.
module mdu_iterative #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] SrcAE,
   input  logic [WIDTH-1:0] SrcBE,
   input  logic [2:0]       MDUControlE,
   output logic [WIDTH-1:0] HiE,
   output logic [WIDTH-1:0] LoE,
   output logic             BusyE,
   output logic             DoneE
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t state, stateNext;

   logic [CW-1:0]    count;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] mq;
   logic [WIDTH-1:0] opReg;
   logic [WIDTH-1:0] aRaw;
   logic             isDiv;
   logic             negRes;
   logic             negRem;
   logic             div0;

   logic             startOp;
   logic             startDiv;
   logic             isSigned;
   logic             wrHi;
   logic             wrLo;
   logic             aNeg;
   logic             bNeg;
   logic [WIDTH-1:0] aAbs;
   logic [WIDTH-1:0] bAbs;

   always_comb begin
      startOp  = 1'b0;
      startDiv = 1'b0;
      isSigned = 1'b0;
      wrHi     = 1'b0;
      wrLo     = 1'b0;
      case (MDUControlE)
         3'd1: begin
            startOp  = 1'b1;
            isSigned = 1'b1;
         end
         3'd2: startOp = 1'b1;
         3'd3: begin
            startOp  = 1'b1;
            startDiv = 1'b1;
            isSigned = 1'b1;
         end
         3'd4: begin
            startOp  = 1'b1;
            startDiv = 1'b1;
         end
         3'd5: wrHi = 1'b1;
         3'd6: wrLo = 1'b1;
         default: ;
      endcase
   end

   assign aNeg = isSigned & SrcAE[WIDTH-1];
   assign bNeg = isSigned & SrcBE[WIDTH-1];
   assign aAbs = aNeg ? -SrcAE : SrcAE;
   assign bAbs = bNeg ? -SrcBE : SrcBE;

   // One iteration: mult adds opReg into the top half then shifts right;
   // div shifts the remainder left and keeps the trial difference if no borrow.
   logic [WIDTH:0]   sum;
   logic [WIDTH:0]   shifted;
   logic [WIDTH:0]   diff;
   logic             qBit;
   logic [WIDTH-1:0] accStep;
   logic [WIDTH-1:0] mqStep;

   always_comb begin
      sum     = {1'b0, acc} + {1'b0, (mq[0] ? opReg : '0)};
      shifted = {acc, mq[WIDTH-1]};
      diff    = shifted - {1'b0, opReg};
      qBit    = ~diff[WIDTH];
      accStep = sum[WIDTH:1];
      mqStep  = {sum[0], mq[WIDTH-1:1]};
      if (isDiv) begin
         accStep = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
         mqStep  = {mq[WIDTH-2:0], qBit};
      end
   end

   logic [2*WIDTH-1:0] prod;
   logic [2*WIDTH-1:0] prodFix;
   logic [WIDTH-1:0]   qFix;
   logic [WIDTH-1:0]   rFix;
   logic [WIDTH-1:0]   hiRes;
   logic [WIDTH-1:0]   loRes;

   always_comb begin
      prod    = {acc, mq};
      prodFix = negRes ? -prod : prod;
      qFix    = negRes ? -mq : mq;
      rFix    = negRem ? -acc : acc;
      hiRes   = prodFix[2*WIDTH-1:WIDTH];
      loRes   = prodFix[WIDTH-1:0];
      if (isDiv) begin
         hiRes = div0 ? aRaw : rFix;
         loRes = div0 ? '1 : qFix;
      end
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:    if (startOp) stateNext = CALC;
         CALC:    if (count == '0) stateNext = FIX;
         FIX:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= stateNext;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         count  <= '0;
         acc    <= '0;
         mq     <= '0;
         opReg  <= '0;
         aRaw   <= '0;
         isDiv  <= 1'b0;
         negRes <= 1'b0;
         negRem <= 1'b0;
         div0   <= 1'b0;
         HiE    <= '0;
         LoE    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (startOp) begin
                  acc    <= '0;
                  mq     <= startDiv ? aAbs : bAbs;
                  opReg  <= startDiv ? bAbs : aAbs;
                  aRaw   <= SrcAE;
                  isDiv  <= startDiv;
                  negRes <= aNeg ^ bNeg;
                  negRem <= aNeg & startDiv;
                  div0   <= startDiv & (SrcBE == '0);
                  count  <= CW'(WIDTH - 1);
               end else begin
                  if (wrHi) HiE <= SrcAE;
                  if (wrLo) LoE <= SrcAE;
               end
            end
            CALC: begin
               acc <= accStep;
               mq  <= mqStep;
               if (count != '0) count <= count - 1'b1;
            end
            FIX: begin
               HiE <= hiRes;
               LoE <= loRes;
            end
            default: ;
         endcase
      end
   end

   assign BusyE = (state != IDLE);
   assign DoneE = (state == FIX);

endmodule

// File: tb/tb_mdu_iterative.sv
// Scoreboard bench for mdu_iterative: directed ops, MTHI/MTLO,
// busy-time interference and mid-operation reset.
module tb_mdu_iterative;

   logic        clk;
   logic        reset;
   logic [31:0] SrcAE;
   logic [31:0] SrcBE;
   logic [2:0]  MDUControlE;
   logic [31:0] HiE;
   logic [31:0] LoE;
   logic        BusyE;
   logic        DoneE;

   int vectors = 0;
   int miscompares = 0;

   logic [63:0] expQ[$];
   logic [31:0] modelHi = 32'd0;
   logic [31:0] modelLo = 32'd0;

   mdu_iterative #(.WIDTH(32)) dut (
      .clk(clk),
      .reset(reset),
      .SrcAE(SrcAE),
      .SrcBE(SrcBE),
      .MDUControlE(MDUControlE),
      .HiE(HiE),
      .LoE(LoE),
      .BusyE(BusyE),
      .DoneE(DoneE)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [31:0] act,
                        input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: a DoneE pulse pops the next expectation; HI/LO are
   // compared one cycle later, after the FIX edge has written them.
   initial begin
      logic [63:0] cur;
      bit pend;
      pend = 1'b0;
      cur = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            check("result HiE", HiE, cur[63:32]);
            check("result LoE", LoE, cur[31:0]);
            pend = 1'b0;
         end
         if (DoneE) begin
            if (expQ.size() == 0) begin
               vectors++;
               miscompares++;
               $display("FAIL unexpected DoneE: got 1 expected 0 at %0t", $time);
            end else begin
               cur = expQ.pop_front();
               pend = 1'b1;
            end
         end
      end
   end

   task automatic runOp(input logic [2:0] c, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] eh,
                        input logic [31:0] el, input bit interfere);
      int cycles;
      expQ.push_back({eh, el});
      @(posedge clk);
      #1 MDUControlE = c;
      SrcAE = a;
      SrcBE = b;
      @(posedge clk);
      #1 MDUControlE = 3'd0;
      SrcAE = $urandom;
      SrcBE = $urandom;
      cycles = 0;
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (!BusyE) break;
         cycles++;
         if (interfere) begin
            if (cycles == 5) begin
               MDUControlE = 3'd6;
               SrcAE = 32'h0000DEAD;
            end else if (cycles == 6) begin
               MDUControlE = 3'd2;
               SrcAE = 32'd3;
               SrcBE = 32'd4;
            end else if (cycles == 7) begin
               MDUControlE = 3'd5;
               SrcAE = 32'h0000BEEF;
            end else if (cycles == 8) begin
               MDUControlE = 3'd0;
            end
         end
         if (cycles == 16) begin
            check("hold HiE", HiE, modelHi);
            check("hold LoE", LoE, modelLo);
         end
      end
      check("busy cycles", 32'(cycles), 32'd33);
      modelHi = eh;
      modelLo = el;
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      MDUControlE = 3'd0;
      SrcAE = 32'd0;
      SrcBE = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("reset HiE", HiE, 32'd0);
      check("reset LoE", LoE, 32'd0);
      check("reset BusyE", 32'(BusyE), 32'd0);
      check("reset DoneE", 32'(DoneE), 32'd0);
      @(posedge clk);
      #1 reset = 1'b0;

      runOp(3'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
      runOp(3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
      runOp(3'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0);
      runOp(3'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
      runOp(3'd3, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0);
      runOp(3'd4, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0);
      runOp(3'd4, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b0);
      runOp(3'd3, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b0);
      runOp(3'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0);

      @(posedge clk);
      #1 MDUControlE = 3'd5;
      SrcAE = 32'h00001234;
      @(posedge clk);
      #1 MDUControlE = 3'd0;
      @(negedge clk);
      check("MTHI HiE", HiE, 32'h00001234);
      check("MTHI LoE", LoE, modelLo);
      check("MTHI BusyE", 32'(BusyE), 32'd0);
      modelHi = 32'h00001234;

      @(posedge clk);
      #1 MDUControlE = 3'd6;
      SrcAE = 32'h00005678;
      @(posedge clk);
      #1 MDUControlE = 3'd0;
      @(negedge clk);
      check("MTLO LoE", LoE, 32'h00005678);
      check("MTLO HiE", HiE, modelHi);
      modelLo = 32'h00005678;

      runOp(3'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b1);
      repeat (40) @(posedge clk);
      check("post-interfere HiE", HiE, 32'hFFFFFFFF);
      check("post-interfere LoE", LoE, 32'hFFFFFFEB);

      @(posedge clk);
      #1 MDUControlE = 3'd2;
      SrcAE = 32'd5;
      SrcBE = 32'd6;
      @(posedge clk);
      #1 MDUControlE = 3'd0;
      repeat (9) @(posedge clk);
      #1 reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("abort BusyE", 32'(BusyE), 32'd0);
      check("abort HiE", HiE, 32'd0);
      check("abort LoE", LoE, 32'd0);
      modelHi = 32'd0;
      modelLo = 32'd0;
      repeat (40) @(posedge clk);

      runOp(3'd2, 32'd3, 32'd4, 32'd0, 32'd12, 1'b0);
      repeat (3) @(posedge clk);
      check("queue drained", 32'(expQ.size()), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
